// File: rtl/ball_motion.sv
// Golf-ball motion engine: launches on a hit, then moves one step per video frame with friction.
// Defining BALL_BOUNCE_EN makes the ball reflect off the field edges instead of stopping there.
module ball_motion #(
    parameter logic [15:0] START_X  = 16'd3200,
    parameter logic [15:0] START_Y  = 16'd11520,
    parameter logic [7:0]  FRICTION = 8'd1
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        hit_in,
    input  logic [7:0]  power_in,
    input  logic [15:0] cos_abs_in,
    input  logic [15:0] sin_abs_in,
    input  logic        cos_sign_in,
    input  logic        sin_sign_in,
    output logic [15:0] ballx_out,
    output logic [15:0] bally_out,
    output logic        moving_out,
    output logic [7:0]  stroke_count_out
);

    localparam logic [15:0] MAX_X = 16'd40959;
    localparam logic [15:0] MAX_Y = 16'd23039;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        STEP,
        APPLY
    } state_t;

    typedef struct packed {
        logic [15:0] pos;
        logic        crossed;
    } axis_result_t;

    state_t       state;
    state_t       next_state;

    logic [7:0]   speed;
    logic [15:0]  cos_abs;
    logic [15:0]  sin_abs;
    logic         cos_neg;
    logic         sin_neg;
    logic [15:0]  dx;
    logic [15:0]  dy;
    logic [15:0]  dx_next;
    logic [15:0]  dy_next;
    logic         accept_hit;
    logic [7:0]   speed_after;
    logic         stop_now;
    axis_result_t res_x;
    axis_result_t res_y;

    // One axis of motion; a landing exactly on a bound is not a crossing.
    function automatic axis_result_t step_axis(
        input logic [15:0] p,
        input logic [15:0] d,
        input logic        neg,
        input logic [15:0] max_pos
    );
        axis_result_t r;
        logic [16:0]  sum;
`ifdef BALL_BOUNCE_EN
        logic [16:0]  twice_max;
        logic [15:0]  diff;
`endif
        r.pos     = p;
        r.crossed = 1'b0;
        sum       = {1'b0, p} + {1'b0, d};
        if (!neg) begin
            if (sum > {1'b0, max_pos}) begin
                r.crossed = 1'b1;
`ifdef BALL_BOUNCE_EN
                twice_max = {max_pos, 1'b0};
                if (sum >= twice_max) begin
                    r.pos = 16'd0;
                end else begin
                    r.pos = 16'(twice_max - sum);
                end
`else
                r.pos = max_pos;
`endif
            end else begin
                r.pos = sum[15:0];
            end
        end else begin
            if (d > p) begin
                r.crossed = 1'b1;
`ifdef BALL_BOUNCE_EN
                diff  = d - p;
                r.pos = (diff > max_pos) ? max_pos : diff;
`else
                r.pos = 16'd0;
`endif
            end else begin
                r.pos = p - d;
            end
        end
        return r;
    endfunction

    // Full 24-bit products so no precision is lost before dropping the 8 fraction bits.
    always_comb begin
        dx_next = 16'(({16'd0, speed} * {8'd0, cos_abs}) >> 8);
        dy_next = 16'(({16'd0, speed} * {8'd0, sin_abs}) >> 8);
    end

    always_comb begin
        res_x       = step_axis(ballx_out, dx, cos_neg, MAX_X);
        res_y       = step_axis(bally_out, dy, sin_neg, MAX_Y);
        speed_after = (speed > FRICTION) ? (speed - FRICTION) : 8'd0;
`ifdef BALL_BOUNCE_EN
        stop_now    = (speed_after == 8'd0);
`else
        stop_now    = (speed_after == 8'd0) || res_x.crossed || res_y.crossed;
`endif
    end

    always_comb begin
        next_state = state;
        accept_hit = 1'b0;
        case (state)
            IDLE: begin
                if (hit_in && (power_in != 8'd0)) begin
                    accept_hit = 1'b1;
                    next_state = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (new_frame_in) begin
                    next_state = STEP;
                end
            end
            STEP: begin
                next_state = APPLY;
            end
            APPLY: begin
                next_state = stop_now ? IDLE : WAIT_FRAME;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            moving_out <= 1'b0;
        end else begin
            state      <= next_state;
            moving_out <= (next_state != IDLE);
        end
    end

    // Direction is captured once per stroke so the aim input can move freely during flight.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            ballx_out        <= START_X;
            bally_out        <= START_Y;
            stroke_count_out <= 8'd0;
            speed            <= 8'd0;
            cos_abs          <= 16'd0;
            sin_abs          <= 16'd0;
            cos_neg          <= 1'b0;
            sin_neg          <= 1'b0;
            dx               <= 16'd0;
            dy               <= 16'd0;
        end else begin
            if (accept_hit) begin
                speed   <= power_in;
                cos_abs <= cos_abs_in;
                sin_abs <= sin_abs_in;
                cos_neg <= cos_sign_in;
                sin_neg <= sin_sign_in;
                if (stroke_count_out != 8'hFF) begin
                    stroke_count_out <= stroke_count_out + 8'd1;
                end
            end
            if (state == STEP) begin
                dx <= dx_next;
                dy <= dy_next;
            end
            if (state == APPLY) begin
                ballx_out <= res_x.pos;
                bally_out <= res_y.pos;
`ifdef BALL_BOUNCE_EN
                speed <= speed_after;
                if (res_x.crossed) begin
                    cos_neg <= ~cos_neg;
                end
                if (res_y.crossed) begin
                    sin_neg <= ~sin_neg;
                end
`else
                speed <= stop_now ? 8'd0 : speed_after;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed scoreboard bench for ball_motion: launch/friction trajectory, ignored hits, reset and edge behaviour.
// Edge expectations follow BALL_BOUNCE_EN when it is defined for the build.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_frame;
    logic        hit;
    logic        frame_e;
    logic        hit_e;
    logic [7:0]  power;
    logic [15:0] cos_abs;
    logic [15:0] sin_abs;
    logic        cos_sign;
    logic        sin_sign;

    logic [15:0] ax, ay, bx, by, cx, cy;
    logic        amov, bmov, cmov;
    logic [7:0]  astroke, bstroke, cstroke;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        bit mov;
    } exp_t;

    exp_t exp_q[$];

    int model_x, model_y, model_speed, model_cos, model_sin, model_strokes;
    bit model_cneg, model_sneg, model_moving;

    ball_motion dut (
        .pixel_clk_in(clk), .rst_in(rst_n), .new_frame_in(new_frame), .hit_in(hit),
        .power_in(power), .cos_abs_in(cos_abs), .sin_abs_in(sin_abs),
        .cos_sign_in(cos_sign), .sin_sign_in(sin_sign),
        .ballx_out(ax), .bally_out(ay), .moving_out(amov), .stroke_count_out(astroke)
    );

    ball_motion #(.START_X(16'd40900)) dut_edge (
        .pixel_clk_in(clk), .rst_in(rst_n), .new_frame_in(frame_e), .hit_in(hit_e),
        .power_in(power), .cos_abs_in(cos_abs), .sin_abs_in(sin_abs),
        .cos_sign_in(cos_sign), .sin_sign_in(sin_sign),
        .ballx_out(bx), .bally_out(by), .moving_out(bmov), .stroke_count_out(bstroke)
    );

    ball_motion #(.START_X(16'd40895)) dut_exact (
        .pixel_clk_in(clk), .rst_in(rst_n), .new_frame_in(frame_e), .hit_in(hit_e),
        .power_in(power), .cos_abs_in(cos_abs), .sin_abs_in(sin_abs),
        .cos_sign_in(cos_sign), .sin_sign_in(sin_sign),
        .ballx_out(cx), .bally_out(cy), .moving_out(cmov), .stroke_count_out(cstroke)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of main-DUT controls (reset is active low), then returns them to idle.
    task automatic applyStimulus(input logic h, input logic [7:0] p, input logic nf, input logic r);
        hit       = h;
        power     = p;
        new_frame = nf;
        rst_n     = r;
        tick();
        hit       = 1'b0;
        new_frame = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic modelReset();
        model_x       = 3200;
        model_y       = 11520;
        model_speed   = 0;
        model_moving  = 1'b0;
        model_strokes = 0;
    endtask

    task automatic modelHit(input int pw);
        if (!model_moving && pw != 0) begin
            model_speed  = pw;
            model_cos    = cos_abs;
            model_sin    = sin_abs;
            model_cneg   = cos_sign;
            model_sneg   = sin_sign;
            model_moving = 1'b1;
            if (model_strokes < 255) model_strokes++;
        end
    endtask

    task automatic modelFrame();
        int dxm, dym;
        if (model_moving) begin
            dxm = (model_speed * model_cos) / 256;
            dym = (model_speed * model_sin) / 256;
            model_x = model_cneg ? model_x - dxm : model_x + dxm;
            model_y = model_sneg ? model_y - dym : model_y + dym;
            model_speed  = (model_speed > 1) ? model_speed - 1 : 0;
            model_moving = (model_speed != 0);
        end
    endtask

    task automatic frameStepA(input string tag);
        exp_t e;
        modelFrame();
        e.x = model_x;
        e.y = model_y;
        e.mov = model_moving;
        exp_q.push_back(e);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
        tick();
        tick();
        e = exp_q.pop_front();
        checkOutput({tag, "_x"}, 32'(ax), 32'(e.x));
        checkOutput({tag, "_y"}, 32'(ay), 32'(e.y));
        checkOutput({tag, "_mov"}, 32'(amov), 32'(e.mov));
    endtask

    task automatic frameStepEdge();
        frame_e = 1'b1;
        tick();
        frame_e = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; hit = 1'b0; new_frame = 1'b0; hit_e = 1'b0; frame_e = 1'b0;
        power = 8'd0; cos_abs = 16'd0; sin_abs = 16'd0; cos_sign = 1'b0; sin_sign = 1'b0;
        modelReset();
        tick();
        tick();
        checkOutput("rst_x", 32'(ax), 32'd3200);
        checkOutput("rst_y", 32'(ay), 32'd11520);
        checkOutput("rst_mov", 32'(amov), 32'd0);
        checkOutput("rst_strokes", 32'(astroke), 32'd0);
        checkOutput("rst_edge_x", 32'(bx), 32'd40900);
        rst_n = 1'b1;
        tick();

        // Edge instances: one crosses the right bound, one lands exactly on it first.
        power = 8'd64; cos_abs = 16'd256; cos_sign = 1'b0; sin_abs = 16'd0; sin_sign = 1'b0;
        hit_e = 1'b1;
        tick();
        hit_e = 1'b0;
        power = 8'd0;
        checkOutput("edge_hit_mov", 32'(bmov), 32'd1);
        checkOutput("edge_hit_strokes", 32'(bstroke), 32'd1);
        frameStepEdge();
        checkOutput("exact_f1_x", 32'(cx), 32'd40959);
        checkOutput("exact_f1_mov", 32'(cmov), 32'd1);
`ifdef BALL_BOUNCE_EN
        checkOutput("edge_f1_x", 32'(bx), 32'd40954);
        checkOutput("edge_f1_mov", 32'(bmov), 32'd1);
        frameStepEdge();
        checkOutput("edge_f2_x", 32'(bx), 32'd40891);
        checkOutput("exact_f2_x", 32'(cx), 32'd40896);
        checkOutput("exact_f2_mov", 32'(cmov), 32'd1);
`else
        checkOutput("edge_f1_x", 32'(bx), 32'd40959);
        checkOutput("edge_f1_mov", 32'(bmov), 32'd0);
        frameStepEdge();
        checkOutput("edge_f2_x", 32'(bx), 32'd40959);
        checkOutput("exact_f2_x", 32'(cx), 32'd40959);
        checkOutput("exact_f2_mov", 32'(cmov), 32'd0);
`endif
        checkOutput("edge_y", 32'(by), 32'd11520);

        // A zero-power hit is ignored.
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b1);
        checkOutput("zero_power_strokes", 32'(astroke), 32'd0);
        checkOutput("zero_power_mov", 32'(amov), 32'd0);

        // Launch straight right at power 64, then disturb the aim inputs.
        cos_abs = 16'd256; cos_sign = 1'b0; sin_abs = 16'd0; sin_sign = 1'b0;
        modelHit(64);
        applyStimulus(1'b1, 8'd64, 1'b0, 1'b1);
        checkOutput("hit_mov", 32'(amov), 32'd1);
        checkOutput("hit_strokes", 32'(astroke), 32'(model_strokes));
        cos_abs = 16'd77; cos_sign = 1'b1; sin_abs = 16'd300;

        for (int f = 1; f <= 64; f++) begin
            frameStepA("run1");
            if (f == 1) checkOutput("run1_f1_x", 32'(ax), 32'd3264);
            if (f == 2) checkOutput("run1_f2_x", 32'(ax), 32'd3327);
            if (f == 5) begin
                applyStimulus(1'b1, 8'd50, 1'b0, 1'b1);
                checkOutput("midflight_hit_strokes", 32'(astroke), 32'd1);
            end
        end
        checkOutput("run1_final_x", 32'(ax), 32'd5280);
        checkOutput("run1_final_y", 32'(ay), 32'd11520);
        checkOutput("run1_final_mov", 32'(amov), 32'd0);
        checkOutput("run1_final_strokes", 32'(astroke), 32'd1);
        frameStepA("idle_frame");

        // Reset, then a hit coinciding with a frame pulse; diagonal up-right this time.
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        modelReset();
        checkOutput("rst2_strokes", 32'(astroke), 32'd0);
        checkOutput("rst2_x", 32'(ax), 32'd3200);
        cos_abs = 16'd256; cos_sign = 1'b0; sin_abs = 16'd128; sin_sign = 1'b1;
        modelHit(64);
        applyStimulus(1'b1, 8'd64, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("hit_frame_x", 32'(ax), 32'd3200);
        checkOutput("hit_frame_mov", 32'(amov), 32'd1);
        checkOutput("hit_frame_strokes", 32'(astroke), 32'd1);
        for (int f = 1; f <= 9; f++) begin
            frameStepA("run2");
            if (f == 1) begin
                checkOutput("run2_f1_x", 32'(ax), 32'd3264);
                checkOutput("run2_f1_y", 32'(ay), 32'd11488);
            end
        end

        // Reset mid-flight together with the tenth frame pulse, then a hit held under reset.
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        modelReset();
        checkOutput("midrst_x", 32'(ax), 32'd3200);
        checkOutput("midrst_y", 32'(ay), 32'd11520);
        checkOutput("midrst_mov", 32'(amov), 32'd0);
        checkOutput("midrst_strokes", 32'(astroke), 32'd0);
        applyStimulus(1'b1, 8'd64, 1'b1, 1'b0);
        checkOutput("hit_in_rst_strokes", 32'(astroke), 32'd0);
        checkOutput("hit_in_rst_mov", 32'(amov), 32'd0);
        for (int f = 0; f < 3; f++) begin
            frameStepA("after_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
